m_dmem_arbiter: RTL and testbench

//   Shares one single-port synchronous data memory (1-cycle read latency, 4096x32) between
//   two requesters: port 0 = pipeline MEM stage, port 1 = debug/loader DMA. Port 0 has fixed

---
 rtl/m_dmem_arbiter.sv | 148 ++++++++++++++
 tb/tb_m_dmem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_dmem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data memory.
// Port 0 (pipeline MEM stage) has fixed priority, limited by an anti-starvation counter;
// port 1 (debug/loader DMA) can lock the memory for bursts. Read data is steered back to
// the port that issued the read, one cycle after the grant.
module m_dmem_arbiter #(
   parameter int unsigned ADDR_W     = 12,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ce_i,
   // port 0: pipeline
   input  logic              p0_req_i,
   input  logic              p0_we_i,
   input  logic [ADDR_W-1:0] p0_addr_i,
   input  logic [DATA_W-1:0] p0_wdata_i,
   output logic              p0_gnt_o,
   output logic              p0_rvalid_o,
   output logic [DATA_W-1:0] p0_rdata_o,
   // port 1: DMA
   input  logic              p1_req_i,
   input  logic              p1_we_i,
   input  logic [ADDR_W-1:0] p1_addr_i,
   input  logic [DATA_W-1:0] p1_wdata_i,
   input  logic              p1_lock_i,
   output logic              p1_gnt_o,
   output logic              p1_rvalid_o,
   output logic [DATA_W-1:0] p1_rdata_o,
   // memory side
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_we_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

   typedef enum logic [0:0] {StArb, StLock} state_e;

   state_e            state_q, state_d;
   logic [3:0]        starve_q, starve_d;
   logic              rv0_q, rv0_d, rv1_q, rv1_d;
   logic [DATA_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
   logic              gnt0, gnt1;
   logic              lock_mode;
   logic              starve_full;

   // State register: FSM state and starvation counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StArb;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   // Next-state logic: enter LOCK on a locked p1 grant, leave when the lock drops
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StArb:   if (gnt1 && p1_lock_i) state_d = StLock;
         StLock:  if (ce_i && !p1_lock_i) state_d = StArb;
         default: state_d = StArb;
      endcase
   end

   // Output logic: grants. The cycle the lock drops is already arbitrated as in ARB.
   always_comb begin
      lock_mode   = (state_q == StLock) && p1_lock_i;
      starve_full = (starve_q == StarveMax);
      gnt0        = 1'b0;
      gnt1        = 1'b0;
      // Grants are gated by rst_n so nothing is granted while reset is held
      if (rst_n && ce_i) begin
         if (lock_mode) begin
            gnt1 = p1_req_i;
         end else begin
            gnt1 = p1_req_i && (!p0_req_i || starve_full);
            gnt0 = p0_req_i && !gnt1;
         end
      end
   end

   assign p0_gnt_o = gnt0;
   assign p1_gnt_o = gnt1;

   // Starvation counter: counts p0 wins while p1 waits; frozen when ce is low
   always_comb begin
      starve_d = starve_q;
      if (ce_i) begin
         if (state_d != state_q) begin
            starve_d = '0;
         end else if (gnt1 || !p1_req_i) begin
            starve_d = '0;
         end else if (gnt0 && !starve_full) begin
            starve_d = starve_q + 4'd1;
         end
      end
   end

   // Memory-side mux: only the granted port reaches the memory, idle drives zeros
   always_comb begin
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_we_o    = 1'b0;
      if (gnt0) begin
         mem_addr_o  = p0_addr_i;
         mem_wdata_o = p0_wdata_i;
         mem_we_o    = p0_we_i;
      end else if (gnt1) begin
         mem_addr_o  = p1_addr_i;
         mem_wdata_o = p1_wdata_i;
         mem_we_o    = p1_we_i;
      end
   end

   // Read-response next state: tracked every cycle, independent of ce, so reads never drop
   always_comb begin
      rv0_d = gnt0 && !p0_we_i;
      rv1_d = gnt1 && !p1_we_i;
      rd0_d = rv0_q ? mem_rdata_i : rd0_q;
      rd1_d = rv1_q ? mem_rdata_i : rd1_q;
   end

   // Read-response registers: valid flags and last captured data per port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rv0_q <= 1'b0;
         rv1_q <= 1'b0;
         rd0_q <= '0;
         rd1_q <= '0;
      end else begin
         rv0_q <= rv0_d;
         rv1_q <= rv1_d;
         rd0_q <= rd0_d;
         rd1_q <= rd1_d;
      end
   end

   assign p0_rvalid_o = rv0_q;
   assign p1_rvalid_o = rv1_q;
   assign p0_rdata_o  = rv0_q ? mem_rdata_i : rd0_q;
   assign p1_rdata_o  = rv1_q ? mem_rdata_i : rd1_q;

endmodule

// File: tb/tb_m_dmem_arbiter.sv
// Bench for m_dmem_arbiter: a behavioural memory, a reference model of the arbitration
// rules, and a scoreboard that matches every granted read to the response that follows.
module tb_m_dmem_arbiter;

   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ce;
   logic        p0_req, p0_we, p0_gnt, p0_rvalid;
   logic [11:0] p0_addr;
   logic [31:0] p0_wdata, p0_rdata;
   logic        p1_req, p1_we, p1_gnt, p1_rvalid, p1_lock;
   logic [11:0] p1_addr;
   logic [31:0] p1_wdata, p1_rdata;
   logic [11:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int          port;
      logic [31:0] data;
      int          due;
   } rsp_t;
   rsp_t sb[$];

   // Model state
   int          m_locked;
   int          m_starve;
   logic [31:0] model_mem [4096];
   logic        e0_last, e1_last;

   m_dmem_arbiter #(
      .ADDR_W(12), .DATA_W(32), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ce_i(ce),
      .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
      .p0_gnt_o(p0_gnt), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
      .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
      .p1_lock_i(p1_lock),
      .p1_gnt_o(p1_gnt), .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
      .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Behavioural single-port memory, 1-cycle read latency
   initial begin
      logic [31:0] mem [4096];
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      mem_rdata = 32'h0;
      forever begin
         @(posedge clk);
         mem_rdata <= mem[mem_addr];
         if (mem_we) mem[mem_addr] = mem_wdata;
      end
   end

   // Reference model + per-cycle checks of grants and memory-side outputs
   initial begin
      logic        e0, e1, ewe;
      logic [11:0] eaddr;
      logic [31:0] ewdata;
      for (int i = 0; i < 4096; i++) model_mem[i] = 32'h0;
      m_locked = 0;
      m_starve = 0;
      e0_last  = 1'b0;
      e1_last  = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_locked = 0;
            m_starve = 0;
            sb.delete();
            e0_last = 1'b0;
            e1_last = 1'b0;
            chk("rst_gnt0", 32'(p0_gnt), 32'd0);
            chk("rst_gnt1", 32'(p1_gnt), 32'd0);
            chk("rst_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'd0);
         end else begin
            e0 = 1'b0;
            e1 = 1'b0;
            if (ce) begin
               if (m_locked != 0 && p1_lock) begin
                  e1 = p1_req;
               end else begin
                  e1 = p1_req && (!p0_req || m_starve == STARVE_MAX);
                  e0 = p0_req && !e1;
               end
            end
            eaddr  = e0 ? p0_addr : (e1 ? p1_addr : 12'h0);
            ewdata = e0 ? p0_wdata : (e1 ? p1_wdata : 32'h0);
            ewe    = (e0 && p0_we) || (e1 && p1_we);
            chk("gnt0", 32'(p0_gnt), 32'(e0));
            chk("gnt1", 32'(p1_gnt), 32'(e1));
            chk("mem_we", 32'(mem_we), 32'(ewe));
            chk("mem_addr", 32'(mem_addr), 32'(eaddr));
            chk("mem_wdata", mem_wdata, ewdata);
            if (p0_gnt && p1_gnt) chk("one_hot_gnt", 32'd1, 32'd0);
            // Expected read responses, due next cycle on the issuing port
            if ((e0 && !p0_we) || (e1 && !p1_we))
               sb.push_back('{port: e0 ? 0 : 1, data: model_mem[eaddr], due: cyc + 1});
            if (ewe) model_mem[eaddr] = ewdata;
            if (ce) begin
               if (m_locked == 0 && e1 && p1_lock) begin
                  m_locked = 1;
                  m_starve = 0;
               end else if (m_locked != 0 && !p1_lock) begin
                  m_locked = 0;
                  m_starve = 0;
               end else if (e1 || !p1_req) begin
                  m_starve = 0;
               end else if (e0) begin
                  m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
               end
            end
            e0_last = e0;
            e1_last = e1;
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents read data
   initial begin
      rsp_t        r;
      logic [31:0] last0, last1;
      last0 = 32'h0;
      last1 = 32'h0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            last0 = 32'h0;
            last1 = 32'h0;
         end else begin
            if (p0_rvalid && p1_rvalid) chk("both_rvalid", 32'd1, 32'd0);
            if (p0_rvalid || p1_rvalid) begin
               if (sb.size() == 0) begin
                  chk("unexpected_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'd0);
               end else begin
                  r = sb.pop_front();
                  chk("rsp_port", 32'(p1_rvalid ? 1 : 0), 32'(r.port));
                  chk("rsp_cycle", 32'(cyc), 32'(r.due));
                  chk("rsp_data", p1_rvalid ? p1_rdata : p0_rdata, r.data);
                  if (r.port == 0) last0 = r.data;
                  else last1 = r.data;
               end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
               r = sb.pop_front();
               chk("missing_rvalid", 32'd0, 32'd1);
            end
            if (!p0_rvalid) chk("p0_rdata_hold", p0_rdata, last0);
            if (!p1_rvalid) chk("p1_rdata_hold", p1_rdata, last1);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
      p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_lock = 1'b0;
      ce = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      repeat (3) step();
      rst_n = 1'b1;
      step();

      // 1: p0 writes mem[5]=A5, then reads it back
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 12'd5; p0_wdata = 32'hA5;
      step();
      p0_we = 1'b0;
      @(negedge clk);
      chk("t1_gnt", 32'(p0_gnt), 32'd1);
      step();
      idle();
      @(negedge clk);
      chk("t1_rvalid", 32'(p0_rvalid), 32'd1);
      chk("t1_rdata", p0_rdata, 32'hA5);
      step();

      // 2: both requesting continuously -> 0,0,0,0,1 repeating
      p0_req = 1'b1; p0_addr = 12'd1;
      p1_req = 1'b1; p1_addr = 12'd2;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t2_pattern", 32'(p1_gnt), 32'((i % 5) == 4));
         step();
      end
      idle();
      step();

      // 3: locked burst of 8 writes while p0 waits, then readback
      for (int i = 0; i < 8; i++) begin
         p1_req = 1'b1; p1_we = 1'b1; p1_lock = 1'b1;
         p1_addr = 12'(i); p1_wdata = 32'h100 + 32'(i);
         p0_req = (i > 0); p0_addr = 12'd20;
         @(negedge clk);
         chk("t3_p0_blocked", 32'(p0_gnt), 32'd0);
         step();
      end
      p1_req = 1'b0; p1_we = 1'b0; p1_lock = 1'b0;
      @(negedge clk);
      chk("t3_p0_after_lock", 32'(p0_gnt), 32'd1);
      step();
      p0_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         p1_req = 1'b1; p1_addr = 12'(i);
         step();
      end
      idle();
      step();

      // 4: ce low for 3 cycles after a granted read
      p0_req = 1'b1; p0_addr = 12'd3;
      p1_req = 1'b1; p1_addr = 12'd4;
      step();
      ce = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t4_no_gnt", 32'({p0_gnt, p1_gnt}), 32'd0);
         chk("t4_no_we", 32'(mem_we), 32'd0);
         if (i == 0) chk("t4_rvalid_kept", 32'(p0_rvalid), 32'd1);
         step();
      end
      ce = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t4_starve_held", 32'(p1_gnt), 32'(i == 3));
         step();
      end
      idle();
      step();

      // 5: reset pulsed mid-lock with a read in flight
      p1_req = 1'b1; p1_lock = 1'b1; p1_addr = 12'd6;
      step();
      p0_req = 1'b1; p0_addr = 12'd9; p1_addr = 12'd7;
      step();
      rst_n = 1'b0;
      #1;
      chk("t5_rst_gnt", 32'({p0_gnt, p1_gnt}), 32'd0);
      chk("t5_rst_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("t5_p0_first", 32'(p0_gnt), 32'd1);
      step();
      idle();
      step();

      // 6: randomized traffic; requests held until the model grants them
      for (int n = 0; n < 10000; n++) begin
         if (!(p0_req && !e0_last)) begin
            p0_req = ($urandom % 3) != 0;
            p0_we = $urandom % 2;
            p0_addr = 12'($urandom % 16);
            p0_wdata = $urandom;
         end
         if (!(p1_req && !e1_last)) begin
            p1_req = ($urandom % 3) != 0;
            p1_we = $urandom % 2;
            p1_addr = 12'($urandom % 16);
            p1_wdata = $urandom;
         end
         if (($urandom % 8) == 0) p1_lock = !p1_lock;
         ce = ($urandom % 10) != 0;
         @(negedge clk);
         step();
      end
      idle();
      repeat (3) step();
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
